conv_loop_controller: RTL and testbench

// Parametrised loop/handshake controller for the convolution datapath, driving super_mac and the operand fetch.

---
 rtl/conv_loop_controller.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_conv_loop_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_controller.sv
// conv_loop_controller
//   Loop/handshake sequencer for the convolution datapath. It walks the output-anchor pixel
//   (y, x), the output channel, the input channel and the kernel tap (k_v, k_h). For each tap it
//   fetches one operand pair and issues one MAC. After the last tap of an output it presents the
//   result coordinates on a valid/ready handshake that supports backpressure. Partial sums stay
//   inside the MAC: mac_accumulate_internal clears the accumulator on the first tap of each output.
//
// Ports
//   clk, arst_n_in            clock (rising edge) and asynchronous active-low reset
//   start                     begin a layer; only sampled while idle
//   conv_stride_mode          0:1 1:2 2:4 3:4; latched on start
//   conv_kernel_size          kernel side 1..MAX_KERNEL; 0 or out of range runs as 1
//   running, done             busy flag; one-cycle pulse after the final result is accepted
//   a_valid/b_valid/a_ready/b_ready   operand fetch handshake
//   mac_valid, mac_accumulate_internal  one MAC per tap; 0 = start a new accumulation
//   x, y, k_h, k_v, ch_in, ch_out      current loop position
//   output_valid/output_ready          result handshake
//   output_x, output_y, output_ch      coordinates of the held result
module conv_loop_controller #(
   parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
   parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
   parameter int unsigned INPUT_NB_CHANNELS  = 64,
   parameter int unsigned OUTPUT_NB_CHANNELS = 64,
   parameter int unsigned MAX_KERNEL         = 7,
   localparam int unsigned KW  = $clog2(MAX_KERNEL + 1),
   localparam int unsigned XW  = (FEATURE_MAP_WIDTH > 1) ? $clog2(FEATURE_MAP_WIDTH) : 1,
   localparam int unsigned YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
   localparam int unsigned CIW = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1,
   localparam int unsigned COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1
) (
   input  logic           clk,
   input  logic           arst_n_in,
   input  logic           start,
   input  logic [1:0]     conv_stride_mode,
   input  logic [KW-1:0]  conv_kernel_size,
   output logic           running,
   output logic           done,
   input  logic           a_valid,
   input  logic           b_valid,
   output logic           a_ready,
   output logic           b_ready,
   output logic           mac_valid,
   output logic           mac_accumulate_internal,
   output logic [XW-1:0]  x,
   output logic [YW-1:0]  y,
   output logic [KW-1:0]  k_h,
   output logic [KW-1:0]  k_v,
   output logic [CIW-1:0] ch_in,
   output logic [COW-1:0] ch_out,
   output logic           output_valid,
   input  logic           output_ready,
   output logic [XW-1:0]  output_x,
   output logic [YW-1:0]  output_y,
   output logic [COW-1:0] output_ch
);

   // Extra headroom so x + stride never wraps in the end-of-row compare.
   localparam int unsigned XCW = XW + 3;
   localparam int unsigned YCW = YW + 3;

   typedef enum logic [1:0] {StIdle, StFetch, StMac, StOut} state_e;

   state_e state_q, state_d;

   logic [KW-1:0]  ksize_q, ksize_d;
   logic [2:0]     stride_q, stride_d;
   logic [KW-1:0]  k_h_q, k_h_d, k_v_q, k_v_d;
   logic [CIW-1:0] ch_in_q, ch_in_d;
   logic [COW-1:0] ch_out_q, ch_out_d;
   logic [XW-1:0]  x_q, x_d, out_x_q, out_x_d;
   logic [YW-1:0]  y_q, y_d, out_y_q, out_y_d;
   logic [COW-1:0] out_ch_q, out_ch_d;
   logic           last_q, last_d;
   logic           done_q, done_d;

   logic           last_kh, last_kv, last_ci, last_co, x_wrap, y_wrap, tap_end;
   logic [XCW-1:0] x_sum;
   logic [YCW-1:0] y_sum;
   logic [31:0]    ksize_in_wide;
   logic [KW-1:0]  ksize_eff;
   logic [2:0]     stride_eff;

   // ---------------------------------------------------------------------------------------
   // Loop-end decode
   // ---------------------------------------------------------------------------------------
   always_comb begin
      last_kh = (k_h_q == ksize_q - KW'(1));
      last_kv = (k_v_q == ksize_q - KW'(1));
      last_ci = (ch_in_q == CIW'(INPUT_NB_CHANNELS - 1));
      last_co = (ch_out_q == COW'(OUTPUT_NB_CHANNELS - 1));
      x_sum   = XCW'(x_q) + XCW'(stride_q);
      y_sum   = YCW'(y_q) + YCW'(stride_q);
      x_wrap  = (x_sum >= XCW'(FEATURE_MAP_WIDTH));
      y_wrap  = (y_sum >= YCW'(FEATURE_MAP_HEIGHT));
      tap_end = last_kh && last_kv && last_ci;
   end

   // Config decode applied at start.
   always_comb begin
      ksize_in_wide = 32'(conv_kernel_size);
      if (ksize_in_wide == 32'd0 || ksize_in_wide > MAX_KERNEL) begin
         ksize_eff = KW'(1);
      end else begin
         ksize_eff = conv_kernel_size;
      end
      unique case (conv_stride_mode)
         2'd0:    stride_eff = 3'd1;
         2'd1:    stride_eff = 3'd2;
         default: stride_eff = 3'd4;
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StFetch;
         StFetch: if (a_valid && b_valid) state_d = StMac;
         StMac:   state_d = tap_end ? StOut : StFetch;
         StOut: begin
            if (output_ready) state_d = last_q ? StIdle : StFetch;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      running                 = 1'b0;
      a_ready                 = 1'b0;
      b_ready                 = 1'b0;
      mac_valid               = 1'b0;
      mac_accumulate_internal = 1'b0;
      output_valid            = 1'b0;
      unique case (state_q)
         StIdle: ;
         StFetch: begin
            running = 1'b1;
            a_ready = 1'b1;
            b_ready = 1'b1;
         end
         StMac: begin
            running                 = 1'b1;
            mac_valid               = 1'b1;
            mac_accumulate_internal = !(ch_in_q == '0 && k_v_q == '0 && k_h_q == '0);
         end
         StOut: begin
            running      = 1'b1;
            output_valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign done      = done_q;
   assign x         = x_q;
   assign y         = y_q;
   assign k_h       = k_h_q;
   assign k_v       = k_v_q;
   assign ch_in     = ch_in_q;
   assign ch_out    = ch_out_q;
   assign output_x  = out_x_q;
   assign output_y  = out_y_q;
   assign output_ch = out_ch_q;

   // ---------------------------------------------------------------------------------------
   // Counters, latched config and result coordinates
   // ---------------------------------------------------------------------------------------
   always_comb begin
      ksize_d  = ksize_q;
      stride_d = stride_q;
      k_h_d    = k_h_q;
      k_v_d    = k_v_q;
      ch_in_d  = ch_in_q;
      ch_out_d = ch_out_q;
      x_d      = x_q;
      y_d      = y_q;
      out_x_d  = out_x_q;
      out_y_d  = out_y_q;
      out_ch_d = out_ch_q;
      last_d   = last_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               ksize_d  = ksize_eff;
               stride_d = stride_eff;
               k_h_d    = '0;
               k_v_d    = '0;
               ch_in_d  = '0;
               ch_out_d = '0;
               x_d      = '0;
               y_d      = '0;
               last_d   = 1'b0;
            end
         end
         StMac: begin
            // Odometer: k_h fastest, then k_v, ch_in, ch_out, x, y.
            if (!last_kh) begin
               k_h_d = k_h_q + KW'(1);
            end else begin
               k_h_d = '0;
               if (!last_kv) begin
                  k_v_d = k_v_q + KW'(1);
               end else begin
                  k_v_d = '0;
                  if (!last_ci) begin
                     ch_in_d = ch_in_q + CIW'(1);
                  end else begin
                     ch_in_d = '0;
                     if (!last_co) begin
                        ch_out_d = ch_out_q + COW'(1);
                     end else begin
                        ch_out_d = '0;
                        // The truncating cast is only taken when x + stride < W.
                        if (!x_wrap) begin
                           x_d = x_q + XW'(stride_q);
                        end else begin
                           x_d = '0;
                           if (!y_wrap) begin
                              y_d = y_q + YW'(stride_q);
                           end else begin
                              y_d = '0;
                           end
                        end
                     end
                  end
               end
            end
            if (tap_end) begin
               out_x_d  = x_q;
               out_y_d  = y_q;
               out_ch_d = ch_out_q;
               last_d   = last_co && x_wrap && y_wrap;
            end
         end
         StOut: begin
            if (output_ready && last_q) done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         ksize_q  <= '0;
         stride_q <= '0;
         k_h_q    <= '0;
         k_v_q    <= '0;
         ch_in_q  <= '0;
         ch_out_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         out_x_q  <= '0;
         out_y_q  <= '0;
         out_ch_q <= '0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         ksize_q  <= ksize_d;
         stride_q <= stride_d;
         k_h_q    <= k_h_d;
         k_v_q    <= k_v_d;
         ch_in_q  <= ch_in_d;
         ch_out_q <= ch_out_d;
         x_q      <= x_d;
         y_q      <= y_d;
         out_x_q  <= out_x_d;
         out_y_q  <= out_y_d;
         out_ch_q <= out_ch_d;
         last_q   <= last_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_conv_loop_controller.sv
module tb_conv_loop_controller;

   localparam int W    = 4;
   localparam int H    = 4;
   localparam int CIN  = 2;
   localparam int COUT = 2;
   localparam int MAXK = 7;

   logic       clk, arst_n_in, start;
   logic [1:0] conv_stride_mode;
   logic [2:0] conv_kernel_size;
   logic       running, done, a_valid, b_valid, a_ready, b_ready;
   logic       mac_valid, mac_accumulate_internal, output_valid, output_ready;
   logic [1:0] x, y, output_x, output_y;
   logic [2:0] k_h, k_v;
   logic       ch_in, ch_out, output_ch;

   int errors = 0;
   int checks = 0;

   conv_loop_controller #(
      .FEATURE_MAP_WIDTH  (W),
      .FEATURE_MAP_HEIGHT (H),
      .INPUT_NB_CHANNELS  (CIN),
      .OUTPUT_NB_CHANNELS (COUT),
      .MAX_KERNEL         (MAXK)
   ) dut (
      .clk                     (clk),
      .arst_n_in               (arst_n_in),
      .start                   (start),
      .conv_stride_mode        (conv_stride_mode),
      .conv_kernel_size        (conv_kernel_size),
      .running                 (running),
      .done                    (done),
      .a_valid                 (a_valid),
      .b_valid                 (b_valid),
      .a_ready                 (a_ready),
      .b_ready                 (b_ready),
      .mac_valid               (mac_valid),
      .mac_accumulate_internal (mac_accumulate_internal),
      .x                       (x),
      .y                       (y),
      .k_h                     (k_h),
      .k_v                     (k_v),
      .ch_in                   (ch_in),
      .ch_out                  (ch_out),
      .output_valid            (output_valid),
      .output_ready            (output_ready),
      .output_x                (output_x),
      .output_y                (output_y),
      .output_ch               (output_ch)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int x; int y; int co; int ci; int kv; int kh; int acc;
   } tap_t;

   typedef struct {
      int x; int y; int co;
   } out_t;

   typedef struct {
      int mode; int k; int exp_macs; int exp_outs;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_running"}, int'(running), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_ready"}, int'(a_ready) + int'(b_ready), 0);
      chk({tag, "_mac_valid"}, int'(mac_valid) + int'(mac_accumulate_internal), 0);
      chk({tag, "_output_valid"}, int'(output_valid), 0);
      chk({tag, "_counters"}, int'(x) + int'(y) + int'(k_h) + int'(k_v) + int'(ch_in)
          + int'(ch_out), 0);
      chk({tag, "_out_coords"}, int'(output_x) + int'(output_y) + int'(output_ch), 0);
   endtask

   function automatic int stride_of(input int mode);
      return (mode == 0) ? 1 : (mode == 1) ? 2 : 4;
   endfunction

   function automatic int keff_of(input int k);
      return (k == 0 || k > MAXK) ? 1 : k;
   endfunction

   // Runs one layer with random valid/ready traffic and checks every tap and result against
   // the loop-nest model. stop_at > 0 asserts reset at that MAC and abandons the layer.
   task automatic run_layer(input int mode, input int k, input int vpct, input int rpct,
                            input int stop_at, input int exp_macs, input int exp_outs);
      tap_t taps[$];
      out_t outs[$];
      tap_t t;
      out_t o;
      int   s, ke, n_mac, n_out, n_done, done_cyc, last_acc_cyc;
      bit   prev_fire, finished, aborted;

      s  = stride_of(mode);
      ke = keff_of(k);
      for (int yy = 0; yy < H; yy += s)
         for (int xx = 0; xx < W; xx += s)
            for (int co = 0; co < COUT; co++) begin
               o = '{xx, yy, co};
               outs.push_back(o);
               for (int ci = 0; ci < CIN; ci++)
                  for (int kv = 0; kv < ke; kv++)
                     for (int kh = 0; kh < ke; kh++) begin
                        t = '{xx, yy, co, ci, kv, kh, (ci == 0 && kv == 0 && kh == 0) ? 0 : 1};
                        taps.push_back(t);
                     end
            end

      @(posedge clk); #1;
      start            = 1'b1;
      conv_stride_mode = 2'(mode);
      conv_kernel_size = 3'(k);
      a_valid          = 1'b0;
      b_valid          = 1'b0;
      output_ready     = 1'b0;

      n_mac = 0; n_out = 0; n_done = 0; done_cyc = -1; last_acc_cyc = -10;
      prev_fire = 1'b0; finished = 1'b0; aborted = 1'b0;

      for (int cyc = 0; cyc < 30000; cyc++) begin
         @(posedge clk); #1;
         // Stray start pulses and config noise while busy must be ignored.
         start            = running ? ($urandom_range(9) == 0) : 1'b0;
         conv_stride_mode = 2'($urandom);
         conv_kernel_size = 3'($urandom);
         a_valid          = ($urandom_range(99) < vpct);
         b_valid          = ($urandom_range(99) < vpct);
         output_ready     = ($urandom_range(99) < rpct);
         @(negedge clk);
         if (mac_valid) begin
            n_mac++;
            chk("mac_after_fetch", int'(prev_fire), 1);
            if (taps.size() > 0) begin
               t = taps.pop_front();
               chk("tap_x", int'(x), t.x);
               chk("tap_y", int'(y), t.y);
               chk("tap_ch_out", int'(ch_out), t.co);
               chk("tap_ch_in", int'(ch_in), t.ci);
               chk("tap_k_v", int'(k_v), t.kv);
               chk("tap_k_h", int'(k_h), t.kh);
               chk("tap_accumulate", int'(mac_accumulate_internal), t.acc);
            end
            if (stop_at > 0 && n_mac == stop_at) begin
               aborted = 1'b1;
               break;
            end
         end
         prev_fire = a_ready && b_ready && a_valid && b_valid;
         if (output_valid) begin
            chk("out_no_mac", int'(mac_valid), 0);
            if (outs.size() > 0) begin
               chk("out_x", int'(output_x), outs[0].x);
               chk("out_y", int'(output_y), outs[0].y);
               chk("out_ch", int'(output_ch), outs[0].co);
               if (output_ready) begin
                  void'(outs.pop_front());
                  n_out++;
                  if (outs.size() == 0) last_acc_cyc = cyc;
               end
            end
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            chk("done_pulse_width", int'(done), 0);
            chk("running_after_done", int'(running), 0);
            finished = 1'b1;
            break;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
      end

      start        = 1'b0;
      a_valid      = 1'b0;
      b_valid      = 1'b0;
      output_ready = 1'b0;

      if (aborted) begin
         arst_n_in = 1'b0;
         #1;
         chk_all_zero("midreset");
         @(posedge clk); #2;
         chk_all_zero("midreset_hold");
         arst_n_in = 1'b1;
      end else begin
         chk("layer_finished", int'(finished), 1);
         chk("mac_count", n_mac, exp_macs);
         chk("out_count", n_out, exp_outs);
         chk("done_count", n_done, 1);
         chk("done_latency", done_cyc, last_acc_cyc + 1);
      end
   endtask

   vec_t vecs[8];
   int   cnt;

   initial begin
      // {mode, k, MACs, outputs} for W=H=4, CIN=COUT=2
      vecs[0] = '{0, 3, 576, 32};
      vecs[1] = '{1, 3, 144, 8};
      vecs[2] = '{2, 3, 36, 2};
      vecs[3] = '{3, 3, 36, 2};
      vecs[4] = '{0, 1, 64, 32};
      vecs[5] = '{1, 0, 16, 8};
      vecs[6] = '{2, 7, 196, 2};
      vecs[7] = '{1, 5, 400, 8};

      arst_n_in        = 1'b1;
      start            = 1'b0;
      conv_stride_mode = 2'd0;
      conv_kernel_size = 3'd0;
      a_valid          = 1'b0;
      b_valid          = 1'b0;
      output_ready     = 1'b0;
      #2 arst_n_in = 1'b0;
      #1 chk_all_zero("reset");
      #19 arst_n_in = 1'b1;

      // Table: always-valid, always-ready layers.
      foreach (vecs[i]) begin
         run_layer(vecs[i].mode, vecs[i].k, 100, 100, 0, vecs[i].exp_macs, vecs[i].exp_outs);
      end

      // Operand stall then output backpressure on a stride-4, k=1 layer.
      @(posedge clk); #1;
      start = 1'b1; conv_stride_mode = 2'd2; conv_kernel_size = 3'd1;
      a_valid = 1'b1; b_valid = 1'b0; output_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_a_ready", int'(a_ready), 1);
         chk("stall_b_ready", int'(b_ready), 1);
         chk("stall_no_mac", int'(mac_valid), 0);
         chk("stall_counters", int'(k_h) + int'(ch_in) + int'(ch_out), 0);
         @(posedge clk); #1;
      end
      b_valid = 1'b1;
      @(negedge clk);
      chk("stall_release_fetch", int'(a_ready), 1);
      @(negedge clk);
      chk("stall_release_mac", int'(mac_valid), 1);
      chk("stall_release_acc", int'(mac_accumulate_internal), 0);
      cnt = 0;
      while (!output_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("bp_output_valid_seen", int'(output_valid), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid_held", int'(output_valid), 1);
         chk("bp_no_mac", int'(mac_valid), 0);
         chk("bp_out_x", int'(output_x), 0);
         chk("bp_out_y", int'(output_y), 0);
         chk("bp_out_ch", int'(output_ch), 0);
      end
      output_ready = 1'b1;
      @(negedge clk);
      chk("bp_released", int'(output_valid), 0);
      cnt = 0;
      while (!done && cnt < 30) begin
         @(negedge clk);
         cnt++;
      end
      chk("bp_done_seen", int'(done), 1);
      @(negedge clk);
      chk("bp_idle", int'(running), 0);
      a_valid = 1'b0; b_valid = 1'b0; output_ready = 1'b0;

      // Reset at MAC #100, then a full layer must reproduce totals with a single done.
      run_layer(0, 3, 100, 100, 100, 576, 32);
      run_layer(0, 3, 100, 100, 0, 576, 32);

      // Random configs and random handshake traffic.
      for (int r = 0; r < 6; r++) begin
         int m, k, s, ke, outs_n;
         m      = int'($urandom_range(3));
         k      = int'($urandom_range(3));
         s      = stride_of(m);
         ke     = keff_of(k);
         outs_n = ((W + s - 1) / s) * ((H + s - 1) / s) * COUT;
         run_layer(m, k, int'($urandom_range(100, 60)), int'($urandom_range(100, 40)), 0,
                   outs_n * CIN * ke * ke, outs_n);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
